// File: rtl/fm_sb_pkg.sv
// Shared spy-buffer definitions: memory word width, widest monitored bus,
// and the state encoding of the write packer.
package fm_sb_pkg;

  localparam int axi_dw     = 32;
  localparam int mon_dw_max = 128;

  // Number of den-sized words needed to hold num bits.
  function automatic int find_ceil(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FROZEN = 2'd2
  } fm_sb_pk_state_t;

endpackage

// File: rtl/fm_sb_write_packer.sv
// Captures one monitored bus frame per fm_vld and writes it into the spy
// buffer as WORDS consecutive axi_dw words, least-significant word first.
module fm_sb_write_packer
  import fm_sb_pkg::*;
#(
  parameter  int TP_DW   = 64,
  parameter  int FRAME_W = 6,
  localparam int WORDS   = find_ceil(TP_DW, axi_dw),
  localparam int IDX_W   = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [mon_dw_max-1:0]    fm_data,
  input  logic                     fm_vld,
  input  logic                     freeze,
  output logic                     wr_en,
  output logic [FRAME_W+IDX_W-1:0] wr_addr,
  output logic [axi_dw-1:0]        wr_data,
  output logic                     frozen,
  output logic [FRAME_W-1:0]       frame_ptr,
  output logic                     wrapped,
  output logic [31:0]              frame_cnt,
  output logic [15:0]              drop_cnt
);

  localparam int              BUF_W    = WORDS * axi_dw;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  fm_sb_pk_state_t               state_q, state_d;
  logic [IDX_W-1:0]              word_idx_q;
  logic [WORDS-1:0][axi_dw-1:0]  buf_q;
  logic [FRAME_W-1:0]            frame_ptr_q;
  logic                          wrapped_q;
  logic [31:0]                   frame_cnt_q;
  logic [15:0]                   drop_cnt_q;
  logic [axi_dw-1:0]             cur_word;
  logic                          last_word;
  logic                          capture;
  logic                          drop;
  logic                          unused_fm;

  // Bits above TP_DW are deliberately ignored.
  assign unused_fm = ^fm_data;

  // freeze always beats a new frame, both from IDLE and on the last word.
  assign last_word = (state_q == SHIFT) && (word_idx_q == LAST_IDX);
  assign capture   = fm_vld && !freeze && ((state_q == IDLE) || last_word);
  assign drop      = fm_vld && (state_q == SHIFT) && !last_word;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (freeze)      state_d = FROZEN;
        else if (fm_vld) state_d = SHIFT;
      end
      SHIFT: begin
        if (last_word) begin
          if (freeze)      state_d = FROZEN;
          else if (fm_vld) state_d = SHIFT;
          else             state_d = IDLE;
        end
      end
      FROZEN: begin
        if (!freeze) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cur_word = '0;
    for (int i = 0; i < WORDS; i++) begin
      if (word_idx_q == IDX_W'(i)) cur_word = buf_q[i];
    end
  end

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    frozen  = (state_q == FROZEN);
    if (state_q == SHIFT) begin
      wr_en   = 1'b1;
      wr_addr = {frame_ptr_q, word_idx_q};
      wr_data = cur_word;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_idx_q  <= '0;
      buf_q       <= '0;
      frame_ptr_q <= '0;
      wrapped_q   <= 1'b0;
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      if (capture) begin
        buf_q      <= BUF_W'(fm_data[TP_DW-1:0]);
        word_idx_q <= '0;
      end else if (state_q == SHIFT) begin
        word_idx_q <= last_word ? '0 : word_idx_q + IDX_W'(1);
      end
      if (last_word) begin
        frame_ptr_q <= frame_ptr_q + FRAME_W'(1);
        frame_cnt_q <= frame_cnt_q + 32'd1;
        if (&frame_ptr_q) wrapped_q <= 1'b1;
      end
      if (drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign frame_ptr = frame_ptr_q;
  assign wrapped   = wrapped_q;
  assign frame_cnt = frame_cnt_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_fm_sb_write_packer.sv
// Scoreboard bench for the spy-buffer write packer: three instances cover
// TP_DW=40 (2 words), TP_DW=100 (4 words) and TP_DW=32 (1 word).
module tb_fm_sb_write_packer;
  import fm_sb_pkg::*;

  typedef struct packed {
    logic [15:0] addr;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [mon_dw_max-1:0] a_data, b_data, c_data;
  logic a_vld, b_vld, c_vld, a_freeze, b_freeze, c_freeze;
  logic a_wr_en, b_wr_en, c_wr_en;
  logic [3:0] a_wr_addr, c_wr_addr;
  logic [4:0] b_wr_addr;
  logic [31:0] a_wr_data, b_wr_data, c_wr_data;
  logic a_frozen, b_frozen, c_frozen;
  logic [2:0] a_ptr, b_ptr, c_ptr;
  logic a_wrapped, b_wrapped, c_wrapped;
  logic [31:0] a_fcnt, b_fcnt, c_fcnt;
  logic [15:0] a_dcnt, b_dcnt, c_dcnt;

  fm_sb_write_packer #(.TP_DW(40), .FRAME_W(3)) u_a (
    .clk(clk), .rst(rst), .fm_data(a_data), .fm_vld(a_vld), .freeze(a_freeze),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data), .frozen(a_frozen),
    .frame_ptr(a_ptr), .wrapped(a_wrapped), .frame_cnt(a_fcnt), .drop_cnt(a_dcnt));

  fm_sb_write_packer #(.TP_DW(100), .FRAME_W(3)) u_b (
    .clk(clk), .rst(rst), .fm_data(b_data), .fm_vld(b_vld), .freeze(b_freeze),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data), .frozen(b_frozen),
    .frame_ptr(b_ptr), .wrapped(b_wrapped), .frame_cnt(b_fcnt), .drop_cnt(b_dcnt));

  fm_sb_write_packer #(.TP_DW(32), .FRAME_W(3)) u_c (
    .clk(clk), .rst(rst), .fm_data(c_data), .fm_vld(c_vld), .freeze(c_freeze),
    .wr_en(c_wr_en), .wr_addr(c_wr_addr), .wr_data(c_wr_data), .frozen(c_frozen),
    .frame_ptr(c_ptr), .wrapped(c_wrapped), .frame_cnt(c_fcnt), .drop_cnt(c_dcnt));

  int vectors = 0;
  int miscompares = 0;
  exp_t q_a[$], q_b[$], q_c[$];
  logic [2:0] ptr_a = 3'd0;
  logic [2:0] ptr_c = 3'd0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Monitors: every write the DUT presents must match the next expected one.
  always @(negedge clk) begin : mon_a
    exp_t e;
    if (a_wr_en === 1'b1) begin
      if (q_a.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL a_unexpected_write: addr 0x%0h data 0x%0h, no write expected", a_wr_addr, a_wr_data);
      end else begin
        e = q_a.pop_front();
        check("a_wr_addr", 64'(a_wr_addr), 64'(e.addr));
        check("a_wr_data", 64'(a_wr_data), 64'(e.data));
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (b_wr_en === 1'b1) begin
      if (q_b.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL b_unexpected_write: addr 0x%0h data 0x%0h, no write expected", b_wr_addr, b_wr_data);
      end else begin
        e = q_b.pop_front();
        check("b_wr_addr", 64'(b_wr_addr), 64'(e.addr));
        check("b_wr_data", 64'(b_wr_data), 64'(e.data));
      end
    end
  end

  always @(negedge clk) begin : mon_c
    exp_t e;
    if (c_wr_en === 1'b1) begin
      if (q_c.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL c_unexpected_write: addr 0x%0h data 0x%0h, no write expected", c_wr_addr, c_wr_data);
      end else begin
        e = q_c.pop_front();
        check("c_wr_addr", 64'(c_wr_addr), 64'(e.addr));
        check("c_wr_data", 64'(c_wr_data), 64'(e.data));
      end
    end
  end

  task automatic push(input int which, input logic [15:0] addr, input logic [31:0] data);
    exp_t e;
    e = '{addr: addr, data: data};
    if (which == 0)      q_a.push_back(e);
    else if (which == 1) q_b.push_back(e);
    else                 q_c.push_back(e);
  endtask

  // One isolated 40-bit frame on instance a; upper bus bits carry junk.
  task automatic send_a(input logic [39:0] d);
    push(0, 16'({ptr_a, 1'b0}), d[31:0]);
    push(0, 16'({ptr_a, 1'b1}), 32'(d[39:32]));
    ptr_a = ptr_a + 3'd1;
    a_data = {{(mon_dw_max-40){1'b1}}, d};
    a_vld = 1'b1;
    tick;
    a_vld = 1'b0;
    tick;
    tick;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [39:0] d40;
    logic [31:0] d32;
    rst = 1'b1;
    a_data = '0; b_data = '0; c_data = '0;
    a_vld = 1'b0; b_vld = 1'b0; c_vld = 1'b0;
    a_freeze = 1'b0; b_freeze = 1'b0; c_freeze = 1'b0;
    tick;
    tick;
    rst = 1'b0;

    // Reset state
    check("rst_wr_en",   64'(a_wr_en),   64'd0);
    check("rst_wr_addr", 64'(a_wr_addr), 64'd0);
    check("rst_wr_data", 64'(a_wr_data), 64'd0);
    check("rst_frozen",  64'(a_frozen),  64'd0);
    check("rst_ptr",     64'(a_ptr),     64'd0);
    check("rst_wrapped", 64'(a_wrapped), 64'd0);
    check("rst_fcnt",    64'(a_fcnt),    64'd0);
    check("rst_dcnt",    64'(a_dcnt),    64'd0);

    // Single 40-bit frame: 0x12345678 to addr 0, 0xAB to addr 1
    send_a(40'hAB_1234_5678);
    check("single_ptr",  64'(a_ptr),  64'd1);
    check("single_fcnt", 64'(a_fcnt), 64'd1);

    // fm_vld held 10 cycles: frames captured on even cycles, drops on odd
    for (int k = 0; k < 10; k++) begin
      d40 = {8'(8'h10 + k), 32'hC0DE_0000 + 32'(k)};
      if (k % 2 == 0) begin
        push(0, 16'({ptr_a, 1'b0}), d40[31:0]);
        push(0, 16'({ptr_a, 1'b1}), 32'(d40[39:32]));
        ptr_a = ptr_a + 3'd1;
      end
      a_data = {{(mon_dw_max-40){1'b0}}, d40};
      a_vld = 1'b1;
      tick;
      check("burst_wr_en", 64'(a_wr_en), 64'd1);
    end
    a_vld = 1'b0;
    tick;
    check("burst_end_wr_en", 64'(a_wr_en), 64'd0);
    check("burst_dcnt", 64'(a_dcnt), 64'd5);
    check("burst_fcnt", 64'(a_fcnt), 64'd6);
    check("burst_ptr",  64'(a_ptr),  64'd6);

    // Pointer wrap after frame 8, frame 9 lands at addr 0/1
    send_a(40'h11_2222_3333);
    check("prewrap_wrapped", 64'(a_wrapped), 64'd0);
    send_a(40'h44_5555_6666);
    check("wrap_ptr",     64'(a_ptr),     64'd0);
    check("wrap_wrapped", 64'(a_wrapped), 64'd1);
    send_a(40'h77_8888_9999);
    check("frame9_fcnt", 64'(a_fcnt), 64'd9);

    // freeze and fm_vld together in IDLE: no capture, no drop
    a_freeze = 1'b1;
    a_vld = 1'b1;
    tick;
    a_vld = 1'b0;
    check("idle_freeze_frozen", 64'(a_frozen), 64'd1);
    tick;
    check("idle_freeze_dcnt", 64'(a_dcnt), 64'd5);
    check("idle_freeze_fcnt", 64'(a_fcnt), 64'd9);
    a_freeze = 1'b0;
    tick;
    check("unfreeze_frozen", 64'(a_frozen), 64'd0);
    send_a(40'hEE_0F0F_0F0F);
    check("after_freeze_fcnt", 64'(a_fcnt), 64'd10);
    check("a_queue_empty", 64'(q_a.size()), 64'd0);

    // One-word frames every cycle: a write every cycle, no drops
    for (int k = 0; k < 10; k++) begin
      d32 = 32'h5A00_0000 + 32'(k);
      push(2, 16'({ptr_c, 1'b0}), d32);
      ptr_c = ptr_c + 3'd1;
      c_data = {{(mon_dw_max-32){1'b1}}, d32};
      c_vld = 1'b1;
      tick;
      check("c_stream_wr_en", 64'(c_wr_en), 64'd1);
    end
    c_vld = 1'b0;
    tick;
    check("c_end_wr_en",  64'(c_wr_en),   64'd0);
    check("c_dcnt",       64'(c_dcnt),    64'd0);
    check("c_fcnt",       64'(c_fcnt),    64'd10);
    check("c_ptr",        64'(c_ptr),     64'd2);
    check("c_wrapped",    64'(c_wrapped), 64'd1);
    check("c_queue_empty", 64'(q_c.size()), 64'd0);

    // 100-bit frame, freeze rises during word 1: words 2 and 3 still written
    push(1, 16'd0, 32'hCAFE_F00D);
    push(1, 16'd1, 32'hDEAD_BEEF);
    push(1, 16'd2, 32'h0123_4567);
    push(1, 16'd3, 32'h0000_000A);
    b_data = {28'hFFF_FFFF, 100'hA_0123_4567_DEAD_BEEF_CAFE_F00D};
    b_vld = 1'b1;
    tick;
    b_vld = 1'b0;
    tick;
    b_freeze = 1'b1;
    tick;
    check("b_word2_wr_en",  64'(b_wr_en),  64'd1);
    tick;
    check("b_word3_wr_en",  64'(b_wr_en),  64'd1);
    check("b_word3_frozen", 64'(b_frozen), 64'd0);
    tick;
    check("b_frozen",       64'(b_frozen), 64'd1);
    check("b_frozen_wr_en", 64'(b_wr_en),  64'd0);
    for (int k = 0; k < 3; k++) begin
      b_vld = 1'b1;
      tick;
      b_vld = 1'b0;
      tick;
      check("b_frozen_ignore_wr_en", 64'(b_wr_en), 64'd0);
    end
    check("b_frozen_dcnt", 64'(b_dcnt), 64'd0);
    check("b_frozen_fcnt", 64'(b_fcnt), 64'd1);
    check("b_frozen_ptr",  64'(b_ptr),  64'd1);
    b_freeze = 1'b0;
    tick;
    check("b_unfreeze", 64'(b_frozen), 64'd0);

    // Next frame lands at frame_ptr=1 (addrs 4..7)
    push(1, 16'd4, 32'h1357_9BDF);
    push(1, 16'd5, 32'h7654_3210);
    push(1, 16'd6, 32'hFEDC_BA98);
    push(1, 16'd7, 32'h0000_0003);
    b_data = {28'h0, 100'h3_FEDC_BA98_7654_3210_1357_9BDF};
    b_vld = 1'b1;
    tick;
    b_vld = 1'b0;
    repeat (4) tick;
    check("b_frame2_fcnt", 64'(b_fcnt), 64'd2);
    check("b_frame2_ptr",  64'(b_ptr),  64'd2);

    // Reset during word 2 abandons the frame (word 3 never written)
    push(1, 16'd8,  32'h5555_6666);
    push(1, 16'd9,  32'h3333_4444);
    push(1, 16'd10, 32'h1111_2222);
    b_data = {28'h0, 100'h0_1111_2222_3333_4444_5555_6666};
    b_vld = 1'b1;
    tick;
    b_vld = 1'b0;
    tick;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("b_rst_wr_en",   64'(b_wr_en),   64'd0);
    check("b_rst_wr_addr", 64'(b_wr_addr), 64'd0);
    check("b_rst_wr_data", 64'(b_wr_data), 64'd0);
    check("b_rst_frozen",  64'(b_frozen),  64'd0);
    check("b_rst_ptr",     64'(b_ptr),     64'd0);
    check("b_rst_fcnt",    64'(b_fcnt),    64'd0);
    check("b_rst_dcnt",    64'(b_dcnt),    64'd0);
    tick;
    check("b_rst_no_word3", 64'(b_wr_en), 64'd0);

    // First frame after reset writes addrs 0..3
    push(1, 16'd0, 32'hFACE_B00C);
    push(1, 16'd1, 32'h1234_1234);
    push(1, 16'd2, 32'hAAAA_5555);
    push(1, 16'd3, 32'h0000_0007);
    b_data = {28'hABC_DEF0, 100'h7_AAAA_5555_1234_1234_FACE_B00C};
    b_vld = 1'b1;
    tick;
    b_vld = 1'b0;
    repeat (4) tick;
    check("b_post_rst_fcnt", 64'(b_fcnt), 64'd1);
    check("b_post_rst_ptr",  64'(b_ptr),  64'd1);
    check("b_queue_empty",   64'(q_b.size()), 64'd0);

    tick;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fm_sb_write_packer.md
FM_SB_WRITE_PACKER -- requirements
Module: fm_sb_write_packer

Interface
REQ-001 SHALL have parameter TP_DW, default 64: width of the monitored bus payload, valid range 1..mon_dw_max.
REQ-002 SHALL have parameter FRAME_W, default 6: frame-pointer width, so the buffer holds 2^FRAME_W frames.
REQ-003 SHALL derive localparam WORDS = find_ceil(TP_DW, axi_dw) and IDX_W = max(1, clog2(WORDS)).
REQ-004 clk  in  1  the single clock for all logic; reset is synchronous and active-high.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 fm_data  in  mon_dw_max  monitored payload; only bits [TP_DW-1:0] are used.
REQ-007 fm_vld  in  1  payload valid strobe, single cycle per frame.
REQ-008 freeze  in  1  level input; while high, stops capture after the current frame.
REQ-009 wr_en  out  1  spy-buffer memory write strobe.
REQ-010 wr_addr  out  FRAME_W+IDX_W  write address {frame_ptr, word_idx}.
REQ-011 wr_data  out  axi_dw  write word.
REQ-012 frozen  out  1  high while in the FROZEN state.
REQ-013 frame_ptr  out  FRAME_W  next frame slot to be written.
REQ-014 wrapped  out  1  sticky flag: frame_ptr has wrapped at least once.
REQ-015 frame_cnt  out  32  count of completed frames, wraps modulo 2^32.
REQ-016 drop_cnt  out  16  count of dropped frames, saturates at 0xFFFF.

Function
REQ-017 States SHALL be IDLE, SHIFT and FROZEN.
- IDLE: fm_vld & !freeze -> latch fm_data[TP_DW-1:0], zero-padded to WORDS*axi_dw; set word_idx=0; go to SHIFT.
- IDLE: freeze -> go to FROZEN. When freeze and fm_vld arrive in the same cycle, freeze wins: the frame is neither captured nor counted as dropped.
REQ-018 In SHIFT, each cycle SHALL drive wr_en=1, wr_data = latched word[word_idx] (word 0 = bits [31:0], LSW first), wr_addr={frame_ptr,word_idx}, then increment word_idx.
REQ-019 First write SHALL occur the cycle after capture, which gives a latency of 1.
REQ-020 On the last-word cycle (word_idx=WORDS-1), the block SHALL:
- increment frame_ptr (wrapping mod 2^FRAME_W) and frame_cnt;
- set wrapped when frame_ptr goes from all-ones to 0;
- go to FROZEN if freeze=1;
- else, if fm_vld, capture the new frame and stay in SHIFT with word_idx=0;
- else return to IDLE.
REQ-021 fm_vld in SHIFT on any cycle other than the last-word cycle SHALL increment drop_cnt (saturating) and leave the current frame intact.
REQ-022 freeze asserted mid-frame SHALL NOT truncate the frame: all WORDS words are written before FROZEN is entered.
REQ-023 In FROZEN, wr_en SHALL be 0 and fm_vld SHALL be ignored, with no drop counted; frame_ptr, wrapped and the counters hold.
REQ-024 FROZEN with freeze=0 SHALL go to IDLE; the next fm_vld is then accepted normally.
REQ-025 With WORDS=1, an fm_vld every cycle SHALL produce a write every cycle with zero drops. Addresses are sparse ({frame_ptr,1'b0}).
REQ-026 wr_data bits at or above TP_DW within the last word SHALL be 0.

Reset
REQ-027 rst SHALL force, on the next edge:
- state=IDLE, wr_en=0, wr_addr=0, wr_data=0, frozen=0;
- frame_ptr=0, wrapped=0, frame_cnt=0, drop_cnt=0.
REQ-028 rst during SHIFT SHALL abandon the partial frame; no further words of it are written.

Structure
REQ-029 axi_dw, mon_dw_max and find_ceil SHALL come from fm_sb_pkg.
REQ-030 The state enum type fm_sb_pk_state_t SHALL be added to fm_sb_pkg.
REQ-031 The block SHALL be a single module with no sub-module; one instance per spy buffer, with TP_DW = sb_tp_dw[i].

Verification
REQ-032 TP_DW=40 (WORDS=2), FRAME_W=3: fm_data=0xAB_1234_5678 with fm_vld at cycle T -> T+1 writes addr 0 / 0x12345678, T+2 writes addr 1 / 0x000000AB; frame_ptr=1, frame_cnt=1.
REQ-033 TP_DW=40, fm_vld held high for 10 cycles -> 5 frames written, drop_cnt=5, wr_en high for 10 consecutive cycles starting T+1.
REQ-034 TP_DW=40, FRAME_W=3, 9 spaced frames -> after frame 8, frame_ptr=0 and wrapped=1; frame 9 writes addr 0 and 1.
REQ-035 TP_DW=100 (WORDS=4): freeze rises during word 1 -> words 2 and 3 are still written, frozen=1 the next cycle, 3 further fm_vld pulses give no wr_en and drop_cnt is unchanged; freeze drops -> the next fm_vld writes at frame_ptr=1.
REQ-036 TP_DW=100: rst asserted at word 2 -> wr_en=0 from the next cycle, all outputs 0; the next frame writes addr 0.
REQ-037 TP_DW=32 (WORDS=1): fm_vld for 10 consecutive cycles -> 10 consecutive writes, addrs 0,2,...,18 mod 2^(FRAME_W+1), drop_cnt=0.
